// File: rtl/booths_mult_param_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The controller drives start/mode/A/B and reads busy/done/M.
interface booths_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   M;

    modport master (
        output start, mode, A, B,
        input  busy, done, M
    );

    modport slave (
        input  start, mode, A, B,
        output busy, done, M
    );
endinterface

// File: rtl/booths_mult_param.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Operands are widened by one bit (sign- or zero-extended by mode), so unsigned
// operands also pass through Booth recoding correctly. One iteration per clock,
// N = WIDTH+1 iterations per product, with back-to-back start accepted in DONE.
module booths_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    booths_mult_param_if.slave  bus
);
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0]         mcand;
    logic [N-1:0]         acc;
    logic [N-1:0]         q;
    logic                 qm1;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   m_q;

    logic                 accept;
    logic                 last;
    logic [N-1:0]         a_ext;
    logic [N-1:0]         b_ext;
    logic [N-1:0]         sum;
    logic [N-1:0]         acc_sh;
    logic [N-1:0]         q_sh;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(1));

    // Operand extension and one Booth add/subtract followed by arithmetic shift
    always_comb begin
        a_ext = bus.mode ? {bus.A[WIDTH-1], bus.A} : {1'b0, bus.A};
        b_ext = bus.mode ? {bus.B[WIDTH-1], bus.B} : {1'b0, bus.B};
        case ({q[0], qm1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_sh = {sum[N-1], sum[N-1:1]};
        q_sh   = {sum[0], q[N-1:1]};
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, Booth iteration, product latch on final step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            acc   <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            m_q   <= '0;
        end else if (accept) begin
            mcand <= a_ext;
            acc   <= '0;
            q     <= b_ext;
            qm1   <= 1'b0;
            cnt   <= CW'(N);
        end else if (state == RUN) begin
            acc <= acc_sh;
            q   <= q_sh;
            qm1 <= q[0];
            cnt <= cnt - CW'(1);
            // The 2N-bit result truncated to 2*WIDTH bits drops the top two acc bits
            if (last) begin
                m_q <= {acc_sh[N-3:0], q_sh};
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.M    = m_q;
endmodule

// File: tb/tb_booths_mult_param.sv
// Directed bench for booths_mult_param: 8-bit and 16-bit instances sharing clock/reset.
module tb_booths_mult_param;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    booths_mult_param_if #(.WIDTH(8))  b8 ();
    booths_mult_param_if #(.WIDTH(16)) b16 ();

    booths_mult_param #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    booths_mult_param #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One 8-bit operation; k=1 is the first negedge after the start edge
    task automatic run_op8(input logic md, input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] m, output int done_at,
                           output int busy_cnt, output int done_cnt);
        m = '0; done_at = 0; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        b8.mode = md; b8.A = a; b8.B = b; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (b8.busy) busy_cnt++;
            if (b8.done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                m = b8.M;
            end
            if (k < 13) @(negedge clk);
        end
    endtask

    task automatic run_op16(input logic md, input logic [15:0] a, input logic [15:0] b,
                            output logic [31:0] m, output int done_at, output int done_cnt);
        m = '0; done_at = 0; done_cnt = 0;
        @(negedge clk);
        b16.mode = md; b16.A = a; b16.B = b; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (b16.done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                m = b16.M;
            end
            if (k < 21) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (b8.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", b8.busy); end
        n_cmp++; if (b8.done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", b8.done); end
        n_cmp++; if (b8.M !== 16'h0000) begin n_err++; $display("FAIL rst_M got %h want 0000", b8.M); end
        n_cmp++; if (b16.M !== 32'h0) begin n_err++; $display("FAIL rst_M16 got %h want 00000000", b16.M); end
        #8 reset = 1'b1;
    endtask

    task automatic test_latency();
        logic [15:0] m; int da, bc, dc;
        run_op8(1'b0, 8'd7, 8'd3, m, da, bc, dc);
        n_cmp++; if (m !== 16'd21) begin n_err++; $display("FAIL lat_M got %h want %h", m, 16'd21); end
        n_cmp++; if (da != 10) begin n_err++; $display("FAIL lat_done_at got %0d want 10", da); end
        n_cmp++; if (bc != 9) begin n_err++; $display("FAIL lat_busy_cycles got %0d want 9", bc); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL lat_done_pulses got %0d want 1", dc); end
        n_cmp++; if (b8.M !== 16'd21) begin n_err++; $display("FAIL lat_M_held got %h want 0015", b8.M); end
    endtask

    task automatic test_unsigned();
        logic [15:0] m; int da, bc, dc;
        run_op8(1'b0, 8'd100, 8'd200, m, da, bc, dc);
        n_cmp++; if (m !== 16'h4E20) begin n_err++; $display("FAIL u_100x200 got %h want 4e20", m); end
        run_op8(1'b0, 8'd255, 8'd255, m, da, bc, dc);
        n_cmp++; if (m !== 16'hFE01) begin n_err++; $display("FAIL u_255x255 got %h want fe01", m); end
        run_op8(1'b0, 8'hF9, 8'd3, m, da, bc, dc);
        n_cmp++; if (m !== 16'h02EB) begin n_err++; $display("FAIL u_249x3 got %h want 02eb", m); end
        run_op8(1'b0, 8'd0, 8'h55, m, da, bc, dc);
        n_cmp++; if (m !== 16'h0000) begin n_err++; $display("FAIL u_0x85 got %h want 0000", m); end
    endtask

    task automatic test_signed();
        logic [15:0] m; int da, bc, dc;
        run_op8(1'b1, 8'hF9, 8'd3, m, da, bc, dc);
        n_cmp++; if (m !== 16'hFFEB) begin n_err++; $display("FAIL s_m7x3 got %h want ffeb", m); end
        run_op8(1'b1, 8'h80, 8'h80, m, da, bc, dc);
        n_cmp++; if (m !== 16'h4000) begin n_err++; $display("FAIL s_m128xm128 got %h want 4000", m); end
        run_op8(1'b1, 8'h80, 8'h7F, m, da, bc, dc);
        n_cmp++; if (m !== 16'hC080) begin n_err++; $display("FAIL s_m128x127 got %h want c080", m); end
        run_op8(1'b1, 8'h7F, 8'h7F, m, da, bc, dc);
        n_cmp++; if (m !== 16'h3F01) begin n_err++; $display("FAIL s_127x127 got %h want 3f01", m); end
        run_op8(1'b1, 8'hFF, 8'hFF, m, da, bc, dc);
        n_cmp++; if (m !== 16'h0001) begin n_err++; $display("FAIL s_m1xm1 got %h want 0001", m); end
    endtask

    task automatic test_start_ignored();
        logic [15:0] m; int da, dc;
        m = '0; da = 0; dc = 0;
        @(negedge clk);
        b8.mode = 1'b0; b8.A = 8'd7; b8.B = 8'd3; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (b8.done) begin dc++; if (da == 0) da = k; m = b8.M; end
            if (k == 3) begin b8.start = 1'b1; b8.A = 8'd9; b8.B = 8'd9; b8.mode = 1'b1; end
            if (k == 4) b8.start = 1'b0;
            if (k < 14) @(negedge clk);
        end
        n_cmp++; if (m !== 16'd21) begin n_err++; $display("FAIL ign_M got %h want 0015", m); end
        n_cmp++; if (da != 10) begin n_err++; $display("FAIL ign_done_at got %0d want 10", da); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL ign_done_pulses got %0d want 1", dc); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m1, m2, mh; int d1, d2, dc; logic busy11;
        m1 = '0; m2 = '0; mh = '0; d1 = 0; d2 = 0; dc = 0; busy11 = 1'b0;
        @(negedge clk);
        b8.mode = 1'b0; b8.A = 8'd7; b8.B = 8'd3; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (b8.done) begin
                dc++;
                if (d1 == 0) begin d1 = k; m1 = b8.M; end
                else begin d2 = k; m2 = b8.M; end
            end
            if (k == 11) busy11 = b8.busy;
            if (k == 15) mh = b8.M;
            if (k == 10) begin b8.start = 1'b1; b8.A = 8'd12; b8.B = 8'd5; end
            if (k == 11) b8.start = 1'b0;
            if (k < 24) @(negedge clk);
        end
        n_cmp++; if (m1 !== 16'd21) begin n_err++; $display("FAIL b2b_M1 got %h want 0015", m1); end
        n_cmp++; if (busy11 !== 1'b1) begin n_err++; $display("FAIL b2b_no_idle busy got %b want 1", busy11); end
        n_cmp++; if (mh !== 16'd21) begin n_err++; $display("FAIL b2b_M_held got %h want 0015", mh); end
        n_cmp++; if (d2 - d1 != 10) begin n_err++; $display("FAIL b2b_interval got %0d want 10", d2 - d1); end
        n_cmp++; if (m2 !== 16'd60) begin n_err++; $display("FAIL b2b_M2 got %h want 003c", m2); end
        n_cmp++; if (dc != 2) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 2", dc); end
    endtask

    task automatic test_width16();
        logic [31:0] m; int da, dc;
        run_op16(1'b0, 16'hFFFF, 16'hFFFF, m, da, dc);
        n_cmp++; if (m !== 32'hFFFE0001) begin n_err++; $display("FAIL w16_u_max got %h want fffe0001", m); end
        n_cmp++; if (da != 18) begin n_err++; $display("FAIL w16_done_at got %0d want 18", da); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL w16_done_pulses got %0d want 1", dc); end
        run_op16(1'b1, 16'h8000, 16'hFFFF, m, da, dc);
        n_cmp++; if (m !== 32'h00008000) begin n_err++; $display("FAIL w16_s_min_x_m1 got %h want 00008000", m); end
    endtask

    task automatic test_reset_mid_run();
        int dc, bc;
        dc = 0; bc = 0;
        @(negedge clk);
        b8.mode = 1'b0; b8.A = 8'd255; b8.B = 8'd255; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (b8.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b want 1", b8.busy); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (b8.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", b8.busy); end
        n_cmp++; if (b8.done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done got %b want 0", b8.done); end
        n_cmp++; if (b8.M !== 16'h0000) begin n_err++; $display("FAIL mid_rst_M got %h want 0000", b8.M); end
        n_cmp++; if (b16.M !== 32'h0) begin n_err++; $display("FAIL mid_rst_M16 got %h want 00000000", b16.M); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (b8.done) dc++;
            if (b8.busy) bc++;
        end
        n_cmp++; if (dc != 0) begin n_err++; $display("FAIL mid_no_done got %0d pulses want 0", dc); end
        n_cmp++; if (bc != 0) begin n_err++; $display("FAIL mid_stays_idle got %0d busy cycles want 0", bc); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0;
        b8.start = 1'b0;  b8.mode = 1'b0;  b8.A = '0;  b8.B = '0;
        b16.start = 1'b0; b16.mode = 1'b0; b16.A = '0; b16.B = '0;
        test_reset();
        test_latency();
        test_unsigned();
        test_signed();
        test_start_ignored();
        test_back_to_back();
        test_width16();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/booths_mult_param.md
Name: booths_mult_param

Overview:
- Parametrised sequential radix-2 Booth multiplier, successor to the team's fixed 8-bit Booth block.
- Generalised to WIDTH-bit operands and a per-operation signed/unsigned mode.
- Adds a busy flag, a single-cycle done pulse, a held result, and back-to-back start acceptance.
- Used as a shared multi-cycle multiply unit under a controller driving start/done.

Parameters:
- WIDTH, 8, operand width in bits (legal >= 2); product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled on a rising edge only when state is IDLE or DONE.
- mode  input  1  1 = two's-complement operands, 0 = unsigned operands; captured with start.
- A  input  WIDTH  multiplicand; captured with start.
- B  input  WIDTH  multiplier; captured with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; M is valid when done is high.
- M  output  2*WIDTH  product; held until the next completion.

Behaviour:
- Internal width: N = WIDTH+1.
  - Operands are extended to N bits: sign-extended if mode=1, zero-extended if mode=0.
  - The extension makes unsigned operands execute correctly through Booth recoding.
- States: IDLE, RUN, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0, M=0, iteration counter=0, internal registers=0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- IDLE:
  - start=1 at edge E0: capture extended A (multiplicand), extended B into Q, Q(-1)=0, accumulator=0, counter=N; go to RUN.
  - start=0: stay in IDLE.
- RUN, one Booth iteration per edge:
  - {Q0,Q(-1)}=01: acc += multiplicand. 10: acc -= multiplicand. 00/11: no add.
  - Then arithmetic right shift of {acc,Q,Q(-1)} by 1; counter decrements.
  - All arithmetic is N-bit two's complement; overflow wraps within N bits, which is correct for Booth.
  - start is ignored in RUN; A/B/mode changes have no effect.
  - Nth iteration (edge EN): M <= low 2*WIDTH bits of {acc,Q}; go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge: if start=1, capture new operands and go to RUN (back-to-back, no idle cycle). Otherwise go to IDLE.
- Outputs: busy = (state==RUN); done = (state==DONE). Both are derived from the registered state and are glitch-free.
- Latency:
  - done is high in the cycle after edge EN, i.e. N clock edges after the start edge.
  - WIDTH=8 gives 9 cycles.
  - Throughput is one result per N+1 cycles with continuous start; with back-to-back start, issue interval is N+1 edges.
- Result rules:
  - Truncating the 2N-bit result to 2*WIDTH bits is exact in both modes.
  - Signed: M is the two's-complement product.
  - Unsigned: M is the unsigned product (max (2^W-1)^2 fits).
- M changes only at the completion edge (or reset); it is stable in IDLE, RUN, and DONE otherwise.
- start held high continuously: a new operation begins every N+1 edges, with operands re-captured each time.

Test Plan:
- WIDTH=8, reset low 20ns then high; mode=0, A=7, B=3, start one cycle -> busy high 9 cycles, done pulses once, 9 edges after start; M=16'd21.
- mode=0, A=100, B=200 -> M=16'h4E20 (20000). mode=0, A=255, B=255 -> M=16'hFE01.
- mode=1, A=8'hF9 (-7), B=3 -> M=16'hFFEB (-21). mode=1, A=8'h80, B=8'h80 -> M=16'h4000. mode=1, A=8'h80, B=8'h7F -> M=16'hC080.
- Pulse start again at RUN cycle 3 with A=9, B=9 -> ignored; first result completes unchanged; done pulses once.
- Hold start=1 across DONE with new A=12, B=5 -> next RUN starts with no IDLE cycle; second done exactly 10 edges after the first, M=60. Assert reset=0 mid-RUN -> busy/done/M go 0 immediately; no done pulse.
- WIDTH=16 instance: mode=0, A=B=16'hFFFF -> M=32'hFFFE0001 after 17 cycles. mode=1, A=16'h8000, B=16'hFFFF -> M=32'h00008000.
